// File: rtl/spectrum_accumulator_if.sv
// Handshake/data bundle between the spectrum accumulator and its controller, FFT source and peak detector.
interface spectrum_accumulator_if #(
    parameter int IN_W      = 24,
    parameter int DATA_W    = 32,
    parameter int PTS_LOG2  = 10,
    parameter int RBIN_LOG2 = 4
);
    logic                            start;
    logic [15:0]                     acc_num;
    logic [RBIN_LOG2:0]              rbin_num;
    logic                            fft_valid;
    logic [IN_W-1:0]                 fft_data;
    logic [DATA_W-1:0]               D_out;
    logic [PTS_LOG2+RBIN_LOG2-1:0]   D_addr;
    logic                            data_valid_out;
    logic [RBIN_LOG2:0]              RangBin_counts;
    logic                            busy;
    logic                            done;
    logic                            overflow;

    modport master (
        output start, acc_num, rbin_num, fft_valid, fft_data,
        input  D_out, D_addr, data_valid_out, RangBin_counts, busy, done, overflow
    );

    modport slave (
        input  start, acc_num, rbin_num, fft_valid, fft_data,
        output D_out, D_addr, data_valid_out, RangBin_counts, busy, done, overflow
    );
endinterface

// File: rtl/spectrum_accumulator.sv
// Accumulates per-pulse FFT power spectra point by point in RAM, then streams the sums out.
// Accumulate is a 3-cycle read-modify-write; dump has 2-cycle read latency with no input stall.
module spectrum_accumulator #(
    parameter int IN_W      = 24,
    parameter int DATA_W    = 32,
    parameter int PTS_LOG2  = 10,
    parameter int RBIN_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    spectrum_accumulator_if.slave  bus
);
    localparam int ADDR_W = PTS_LOG2 + RBIN_LOG2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int RB_W   = RBIN_LOG2 + 1;
    localparam int SUM_W  = DATA_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DUMP  = 2'd2;

    logic [1:0]            r_state;
    logic [15:0]           r_acc_m1;
    logic [RBIN_LOG2-1:0]  r_rbin_m1;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [15:0]           r_pulse_cnt;
    logic                  r_in_done;

    logic                  r_s1_vld;
    logic [ADDR_W-1:0]     r_s1_addr;
    logic [IN_W-1:0]       r_s1_dat;
    logic                  r_s1_first;
    logic                  r_s2_vld;
    logic [ADDR_W-1:0]     r_s2_addr;
    logic [DATA_W-1:0]     r_s2_sum;

    logic [ADDR_W-1:0]     r_rd_addr;
    logic                  r_rd_act;
    logic                  r_d1_vld;
    logic [ADDR_W-1:0]     r_d1_addr;
    logic                  r_d1_last;

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [DATA_W-1:0]     r_mem_q;

    logic [DATA_W-1:0]     r_dout;
    logic [ADDR_W-1:0]     r_daddr;
    logic                  r_dvld;
    logic                  r_dlast;
    logic [RB_W-1:0]       r_rbc;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_ovf;

    logic [ADDR_W-1:0]     w_last_addr;
    logic                  w_accept;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic [SUM_W-1:0]      w_sum_ext;
    logic                  w_sat;
    logic [DATA_W-1:0]     w_wr_val;
    logic                  w_drained;
    logic [RBIN_LOG2-1:0]  w_rbin_m1;

    assign w_last_addr = {r_rbin_m1, {PTS_LOG2{1'b1}}};
    assign w_accept    = (r_state == S_ACCUM) && bus.fft_valid && !r_in_done;
    assign w_rd_addr   = (r_state == S_DUMP) ? r_rd_addr : r_wr_addr;
    assign w_sum_ext   = {1'b0, r_mem_q} + SUM_W'(r_s1_dat);
    // The first pulse overwrites whatever the RAM holds, so it never saturates.
    assign w_sat       = !r_s1_first && w_sum_ext[DATA_W];
    assign w_wr_val    = r_s1_first ? DATA_W'(r_s1_dat) :
                         (w_sat ? {DATA_W{1'b1}} : w_sum_ext[DATA_W-1:0]);
    assign w_drained   = r_in_done && !r_s1_vld && !r_s2_vld;

    always_comb begin
        w_rbin_m1 = RBIN_LOG2'(bus.rbin_num - RB_W'(1));
        if (bus.rbin_num == '0)
            w_rbin_m1 = '0;
        else if (bus.rbin_num > RB_W'(1 << RBIN_LOG2))
            w_rbin_m1 = '1;
    end

    always_ff @(posedge clk) begin
        if (r_s2_vld)
            r_mem[r_s2_addr] <= r_s2_sum;
        r_mem_q <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc_m1    <= '0;
            r_rbin_m1   <= '0;
            r_wr_addr   <= '0;
            r_pulse_cnt <= '0;
            r_in_done   <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s1_addr   <= '0;
            r_s1_dat    <= '0;
            r_s1_first  <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_addr   <= '0;
            r_s2_sum    <= '0;
            r_rd_addr   <= '0;
            r_rd_act    <= 1'b0;
            r_d1_vld    <= 1'b0;
            r_d1_addr   <= '0;
            r_d1_last   <= 1'b0;
            r_dout      <= '0;
            r_daddr     <= '0;
            r_dvld      <= 1'b0;
            r_dlast     <= 1'b0;
            r_rbc       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done     <= 1'b0;

            r_s1_vld   <= w_accept;
            r_s1_addr  <= r_wr_addr;
            r_s1_dat   <= bus.fft_data;
            r_s1_first <= (r_pulse_cnt == '0);
            r_s2_vld   <= r_s1_vld;
            r_s2_addr  <= r_s1_addr;
            r_s2_sum   <= w_wr_val;
            if (r_s1_vld && w_sat)
                r_ovf <= 1'b1;

            // Output stage zeroes everything outside the valid window.
            r_d1_vld  <= (r_state == S_DUMP) && r_rd_act;
            r_d1_addr <= r_rd_addr;
            r_d1_last <= (r_rd_addr == w_last_addr);
            r_dvld    <= r_d1_vld;
            r_dlast   <= r_d1_vld && r_d1_last;
            r_dout    <= r_d1_vld ? r_mem_q : '0;
            r_daddr   <= r_d1_vld ? r_d1_addr : '0;
            r_rbc     <= r_d1_vld ? ({1'b0, r_d1_addr[ADDR_W-1 -: RBIN_LOG2]} + RB_W'(1)) : '0;

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc_m1    <= (bus.acc_num == '0) ? 16'd0 : bus.acc_num - 16'd1;
                        r_rbin_m1   <= w_rbin_m1;
                        r_wr_addr   <= '0;
                        r_pulse_cnt <= '0;
                        r_in_done   <= 1'b0;
                        r_ovf       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (r_wr_addr == w_last_addr) begin
                            r_wr_addr <= '0;
                            if (r_pulse_cnt == r_acc_m1)
                                r_in_done <= 1'b1;
                            else
                                r_pulse_cnt <= r_pulse_cnt + 16'd1;
                        end else begin
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        end
                    end
                    if (w_drained) begin
                        r_rd_addr <= '0;
                        r_rd_act  <= 1'b1;
                        r_state   <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (r_rd_act) begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        if (r_rd_addr == w_last_addr)
                            r_rd_act <= 1'b0;
                    end
                    if (r_dvld && r_dlast) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.D_out          = r_dout;
    assign bus.D_addr         = r_daddr;
    assign bus.data_valid_out = r_dvld;
    assign bus.RangBin_counts = r_rbc;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.overflow       = r_ovf;
endmodule

// File: tb/tb_spectrum_accumulator.sv
// Bench for spectrum_accumulator: vector table of runs plus reset and start-during-dump sequences.
// Accumulator width is narrowed so that saturation is reachable within a few pulses.
module tb_spectrum_accumulator;
    localparam int     DW   = 26;
    localparam int     NMAX = 16384;
    localparam longint MAXV = (longint'(1) << DW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spectrum_accumulator_if #(.IN_W(24), .DATA_W(DW), .PTS_LOG2(10), .RBIN_LOG2(4)) bus ();
    spectrum_accumulator #(.IN_W(24), .DATA_W(DW), .PTS_LOG2(10), .RBIN_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [13:0]   a;
        logic [4:0]    r;
    } exp_t;

    typedef struct {
        int acc;
        int rbin;
        int mode;      // 0: ramp fft_data = point index, 1: constant cval
        int cval;
        int gap;       // percent chance of an idle cycle before each sample
        int exp_n;
        bit exp_ovf;
    } vec_t;

    exp_t          sb_q[$];
    exp_t          e;
    logic [DW-1:0] mdl [NMAX];
    vec_t          vt [6];

    int n_chk = 0, n_pass = 0;
    int vld_cnt = 0, done_cnt = 0, burst_cnt = 0;
    int base_vld, base_done, base_burst;
    bit prev_vld = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.data_valid_out) begin
                vld_cnt++;
                if (!prev_vld) burst_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("d_out", bus.D_out, e.d);
                    chk("d_addr", bus.D_addr, e.a);
                    chk("rangbin_counts", bus.RangBin_counts, e.r);
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_follows_last_sample", prev_vld, 1);
                chk("valid_low_at_done", bus.data_valid_out, 0);
                chk("busy_low_at_done", bus.busy, 0);
            end
            prev_vld = bus.data_valid_out;
        end
    end

    task automatic start_run(input int acc, input int rbin);
        bus.acc_num  = 16'(acc);
        bus.rbin_num = 5'(rbin);
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        base_vld   = vld_cnt;
        base_done  = done_cnt;
        base_burst = burst_cnt;
        chk("busy_after_start", bus.busy, 1);
        chk("overflow_cleared_at_start", bus.overflow, 0);
    endtask

    // Drives samples and updates the reference model; limit < 0 means all pulses.
    task automatic feed(input int acc_eff, input int npts, input int mode, input int cval,
                        input int gap, input int limit);
        int     cnt = 0;
        longint s;
        logic [23:0] d;
        for (int p = 0; p < acc_eff; p++) begin
            for (int i = 0; i < npts; i++) begin
                if (limit >= 0 && cnt >= limit) break;
                d = (mode == 0) ? 24'(i) : 24'(cval);
                while ($urandom_range(99, 0) < gap) begin
                    bus.fft_valid = 1'b0;
                    tick();
                end
                bus.fft_valid = 1'b1;
                bus.fft_data  = d;
                if (p == 0) begin
                    mdl[i] = DW'(d);
                end else begin
                    s = longint'(mdl[i]) + longint'(d);
                    mdl[i] = (s > MAXV) ? DW'(MAXV) : DW'(s);
                end
                tick();
                cnt++;
            end
        end
        bus.fft_valid = 1'b0;
    endtask

    task automatic push_exp(input int npts);
        for (int i = 0; i < npts; i++)
            sb_q.push_back('{d: mdl[i], a: 14'(i), r: 5'((i >> 10) + 1)});
    endtask

    task automatic wait_done(input int exp_n);
        bit seen = 1'b0;
        for (int c = 0; c < exp_n + 200; c++) begin
            tick();
            if (done_cnt != base_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        chk("one_done_pulse", done_cnt - base_done, 1);
        chk("busy_after_done", bus.busy, 0);
        chk("sample_count", vld_cnt - base_vld, exp_n);
        chk("contiguous_valid", burst_cnt - base_burst, 1);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("rangbin_zero_when_idle", bus.RangBin_counts, 0);
    endtask

    initial begin
        int acc_eff, rb_eff, npts;
        bit seen;

        bus.start     = 1'b0;
        bus.acc_num   = '0;
        bus.rbin_num  = '0;
        bus.fft_valid = 1'b0;
        bus.fft_data  = '0;

        vt[0] = '{acc: 1,   rbin: 1,  mode: 0, cval: 0,        gap: 0,  exp_n: 1024,  exp_ovf: 0};
        vt[1] = '{acc: 4,   rbin: 2,  mode: 1, cval: 100,      gap: 0,  exp_n: 2048,  exp_ovf: 0};
        vt[2] = '{acc: 4,   rbin: 2,  mode: 1, cval: 100,      gap: 30, exp_n: 2048,  exp_ovf: 0};
        vt[3] = '{acc: 8,   rbin: 1,  mode: 1, cval: 'hFFFFFF, gap: 0,  exp_n: 1024,  exp_ovf: 1};
        vt[4] = '{acc: 1,   rbin: 1,  mode: 0, cval: 0,        gap: 0,  exp_n: 1024,  exp_ovf: 0};
        vt[5] = '{acc: 0,   rbin: 20, mode: 0, cval: 0,        gap: 0,  exp_n: 16384, exp_ovf: 0};

        repeat (3) @(negedge clk);
        chk("rst_d_out", bus.D_out, 0);
        chk("rst_d_addr", bus.D_addr, 0);
        chk("rst_valid", bus.data_valid_out, 0);
        chk("rst_rangbin", bus.RangBin_counts, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_overflow", bus.overflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            acc_eff = (vt[k].acc == 0) ? 1 : vt[k].acc;
            rb_eff  = (vt[k].rbin == 0) ? 1 : ((vt[k].rbin > 16) ? 16 : vt[k].rbin);
            npts    = rb_eff * 1024;
            start_run(vt[k].acc, vt[k].rbin);
            feed(acc_eff, npts, vt[k].mode, vt[k].cval, vt[k].gap, -1);
            push_exp(npts);
            wait_done(vt[k].exp_n);
            chk("overflow_flag", bus.overflow, vt[k].exp_ovf);
        end

        // Reset partway through the third of four pulses, then a fresh run.
        start_run(4, 1);
        feed(4, 1024, 1, 55, 0, 2 * 1024 + 500);
        rst = 1'b1;
        tick();
        chk("midrun_rst_busy", bus.busy, 0);
        chk("midrun_rst_valid", bus.data_valid_out, 0);
        chk("midrun_rst_d_out", bus.D_out, 0);
        chk("midrun_rst_overflow", bus.overflow, 0);
        tick();
        rst = 1'b0;
        tick();
        start_run(1, 1);
        feed(1, 1024, 1, 7, 0, -1);
        push_exp(1024);
        wait_done(1024);

        // acc_num=0 / rbin_num=0 run, with start and fft_valid poked during the dump.
        start_run(0, 0);
        feed(1, 1024, 0, 0, 0, -1);
        push_exp(1024);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.data_valid_out) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("dump_started", seen, 1);
        bus.acc_num   = 16'd5;
        bus.rbin_num  = 5'd3;
        bus.start     = 1'b1;
        bus.fft_valid = 1'b1;
        bus.fft_data  = 24'd999;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.fft_valid = 1'b0;
        wait_done(1024);
        repeat (30) tick();
        chk("ignored_start_busy", bus.busy, 0);
        chk("ignored_start_done_count", done_cnt - base_done, 1);
        chk("ignored_start_samples", vld_cnt - base_vld, 1024);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/spectrum_accumulator.md
Name: spectrum_accumulator

Overview:
- Upstream feeder of the peak-detection stage.
- Takes per-pulse FFT power spectra for up to 16 range bins of 1024 points each and accumulates them point by point over a programmed number of pulses in an internal RAM.
- Streams the accumulated spectra out sequentially with range-bin index and 14-bit address, in the form the peak detector consumes (D_out, D_addr, data_valid, RangBin_counts).

Parameters:
- IN_W, 24, width of incoming power sample (unsigned).
- DATA_W, 32, accumulator/output width (unsigned).
- PTS_LOG2, 10, log2 FFT points per range bin (1024).
- RBIN_LOG2, 4, log2 max range bins (16); RAM depth = 2^(PTS_LOG2+RBIN_LOG2) = 16384.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- acc_num  in  16  pulses to accumulate; sampled at start.
- rbin_num  in  5  range bins per pulse; sampled at start.
- fft_valid  in  1  fft_data valid this cycle.
- fft_data  in  IN_W  power sample; implicit sequential point order.
- D_out  out  DATA_W  accumulated value.
- D_addr  out  14  {range-bin index[3:0], point[9:0]} of D_out.
- data_valid_out  out  1  D_out/D_addr valid.
- RangBin_counts  out  5  range-bin index+1 of current output sample; 0 when not valid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after last output sample.
- overflow  out  1  sticky; any accumulation saturated this run.

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0. RAM contents are don't-care, because the first pulse overwrites them.
- Run setup at accepted start:
  - acc_num and rbin_num are latched.
  - acc_num = 0 is treated as 1.
  - rbin_num = 0 is treated as 1; rbin_num > 16 is clamped to 16.
  - N_pts = rbin_num_eff*1024.
  - overflow clears.
  - start while busy is ignored.
- FSM states: IDLE -> ACCUM (on start) -> DUMP (after acc_num_eff pulses fully written) -> IDLE (after last sample is output; done pulses in that cycle).
- ACCUM, point indexing:
  - Write address counter wr_addr starts at 0 and increments per fft_valid.
  - It wraps to 0 after N_pts-1 and bumps the pulse counter at that point.
  - Gaps in fft_valid are allowed at any point.
- ACCUM, read-modify-write pipeline:
  - Cycle 0: sample accepted, RAM read issued at wr_addr.
  - Cycle 1: RAM data returns.
  - Cycle 2: sum written.
  - Addresses are strictly sequential, so no RAW hazard exists. This includes the wrap, where the last write at N_pts-1 is distinct from read address 0.
- ACCUM, value written:
  - Pulse 0: writes the zero-extended fft_data and ignores RAM content.
  - Later pulses: write RAM + fft_data, saturating at 2^DATA_W-1.
  - Any saturation sets overflow (sticky until next start).
- ACCUM -> DUMP transition: only after the final write of the last pulse has committed (pipeline drained). fft_valid is ignored outside ACCUM.
- DUMP:
  - Read address rd_addr runs 0..N_pts-1, one per cycle, no stalls.
  - Read latency is 2 cycles. D_out, D_addr and data_valid_out are registered together and mutually aligned.
  - data_valid_out is high for exactly N_pts contiguous cycles.
  - RangBin_counts = D_addr[13:10]+1 while valid.
- done: asserted the cycle after the last valid sample; busy falls in the same cycle.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The next run's results reflect only the new data.

Test Plan:
- acc_num=1, rbin_num=1, fft_data=i for i=0..1023 -> 1024 contiguous valid cycles, D_out=i, D_addr=i, RangBin_counts=1, done 1 cycle after the last sample, overflow=0.
- acc_num=4, rbin_num=2, fft_data=100 constant -> 2048 valid samples, all D_out=400; RangBin_counts=1 for D_addr 0..1023 and 2 for 1024..2047.
- Same as previous with random fft_valid gaps (about 30% low) -> output identical to the gap-free case.
- acc_num=300, rbin_num=1, fft_data=24'hFFFFFF -> all D_out=32'hFFFFFFFF, overflow=1; the following run with acc_num=1 clears overflow to 0.
- Assert rst mid-ACCUM (pulse 2 of 4), then run acc_num=1 with fft_data=7 -> all D_out=7, no stale data.
- start pulsed during DUMP -> ignored; exactly one done pulse, busy low after it. Also check acc_num=0 and rbin_num=0 behave as 1, and rbin_num=20 yields 16384 samples.
